multiplier_control: RTL and testbench

MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

---
 rtl/multiplier_control.sv | 122 ++++++++++++
 tb/tb_multiplier_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_control.sv
// Sequencer for a shift-and-add signed multiplier. It steps the A/B/S
// register unit through N_BITS add/shift iterations, subtracting on the
// last one (the multiplier's sign bit), then holds Done until Run drops.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for Run; operand loads pass straight through
// S_CLEAR | one-cycle clear of A, iteration counter restarts at 0
// S_ADD   | conditional add (or subtract on the last iteration) of S
// S_SHIFT | shift A:B right, advance the iteration or finish
// S_HOLD  | result valid, wait for Run to be released
module multiplier_control #(
    parameter int N_BITS = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      ClearA_LoadB,
    input  logic                      LoadS,
    input  logic                      M,
    output logic                      Clr_A,
    output logic                      Ld_A,
    output logic                      Ld_B,
    output logic                      Ld_S,
    output logic                      Shift_En,
    output logic                      Sub,
    output logic                      Busy,
    output logic                      Done,
    output logic [$clog2(N_BITS)-1:0] Iter
);

    localparam int IW = $clog2(N_BITS);
    localparam logic [IW-1:0] LAST_ITER = IW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          clr_q, clr_d;
    logic          shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          idle_load;

    // Next-state and iteration logic; state-only outputs are decoded from
    // the next state so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                iter_d  = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (iter_q == LAST_ITER) begin
                    state_d = S_HOLD;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (!Run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        clr_d   = (state_d == S_CLEAR);
        shift_d = (state_d == S_SHIFT);
        busy_d  = (state_d == S_CLEAR) || (state_d == S_ADD) || (state_d == S_SHIFT);
        done_d  = (state_d == S_HOLD);
    end

    // State, counter and registered outputs; reset aborts any multiply at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            clr_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            clr_q   <= clr_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand loads act in the same cycle while idle; Run wins over them and
    // Reset gates them so nothing reaches the register unit during reset.
    // Ld_A/Sub must follow M combinationally: B[0] only settles after the
    // preceding shift, so a registered version would see the stale bit.
    always_comb begin
        idle_load = (state_q == S_IDLE) && !Run && !Reset;
        Ld_B      = idle_load && ClearA_LoadB;
        Ld_S      = idle_load && LoadS;
        Clr_A     = clr_q || (idle_load && ClearA_LoadB);
        Ld_A      = (state_q == S_ADD) && M;
        Sub       = (state_q == S_ADD) && M && (iter_q == LAST_ITER);
        Shift_En  = shift_q;
        Busy      = busy_q;
        Done      = done_q;
        Iter      = iter_q;
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control: N_BITS=8 and N_BITS=4 instances.
module tb_multiplier_control;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset, Run, cl, ls, M, Run4, M4;
    logic Clr_A, Ld_A, Ld_B, Ld_S, Shift_En, Sub, Busy, Done;
    logic [2:0] Iter;
    logic Clr_A4, Ld_A4, Ld_B4, Ld_S4, Shift_En4, Sub4, Busy4, Done4;
    logic [1:0] Iter4;

    wire [7:0] outs8 = {Clr_A, Ld_A, Ld_B, Ld_S, Shift_En, Sub, Busy, Done};
    wire [7:0] outs4 = {Clr_A4, Ld_A4, Ld_B4, Ld_S4, Shift_En4, Sub4, Busy4, Done4};

    int n_cmp = 0;
    int n_err = 0;

    multiplier_control #(.N_BITS(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(cl), .LoadS(ls), .M(M),
        .Clr_A(Clr_A), .Ld_A(Ld_A), .Ld_B(Ld_B), .Ld_S(Ld_S), .Shift_En(Shift_En),
        .Sub(Sub), .Busy(Busy), .Done(Done), .Iter(Iter)
    );

    multiplier_control #(.N_BITS(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Run(Run4), .ClearA_LoadB(cl), .LoadS(ls), .M(M4),
        .Clr_A(Clr_A4), .Ld_A(Ld_A4), .Ld_B(Ld_B4), .Ld_S(Ld_S4), .Shift_En(Shift_En4),
        .Sub(Sub4), .Busy(Busy4), .Done(Done4), .Iter(Iter4)
    );

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset;
        Reset = 1'b1; Run = 1'b0; Run4 = 1'b0; cl = 1'b0; ls = 1'b0; M = 1'b0; M4 = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Run = 1'b0; Run4 = 1'b0; cl = 1'b1; ls = 1'b1; M = 1'b1; M4 = 1'b1;
        #2;
        n_cmp++;
        if (outs8 !== 8'b0) begin n_err++; $display("FAIL reset_outs8: got %b want %b", outs8, 8'b0); end
        n_cmp++;
        if (Iter !== 3'd0) begin n_err++; $display("FAIL reset_iter8: got %0d want 0", Iter); end
        n_cmp++;
        if (outs4 !== 8'b0) begin n_err++; $display("FAIL reset_outs4: got %b want %b", outs4, 8'b0); end
        do_reset();
    endtask

    task automatic test_idle_loads;
        @(negedge Clk);
        Run = 1'b0; cl = 1'b1; ls = 1'b1; #1;
        n_cmp++;
        if (outs8 !== 8'b1011_0000) begin n_err++; $display("FAIL idle_both_loads: got %b want %b", outs8, 8'b1011_0000); end
        cl = 1'b1; ls = 1'b0; #1;
        n_cmp++;
        if (outs8 !== 8'b1010_0000) begin n_err++; $display("FAIL idle_loadb_only: got %b want %b", outs8, 8'b1010_0000); end
        cl = 1'b0; ls = 1'b1; #1;
        n_cmp++;
        if (outs8 !== 8'b0001_0000) begin n_err++; $display("FAIL idle_loads_only: got %b want %b", outs8, 8'b0001_0000); end
        Run = 1'b1; cl = 1'b1; ls = 1'b1; M = 1'b0; #1;
        n_cmp++;
        if (outs8 !== 8'b0000_0000) begin n_err++; $display("FAIL idle_run_priority: got %b want %b", outs8, 8'b0); end
        tick();
        n_cmp++;
        if (outs8 !== 8'b1000_0010) begin n_err++; $display("FAIL clear_state: got %b want %b", outs8, 8'b1000_0010); end
        tick();
        n_cmp++;
        if (outs8 !== 8'b0000_0010) begin n_err++; $display("FAIL add_ignores_loads: got %b want %b", outs8, 8'b0000_0010); end
        do_reset();
    endtask

    task automatic test_multiply8;
        logic [7:0] m_pat;
        logic [7:0] exp;
        int ld_cnt, sh_cnt, sub_cnt, overlap, done_first, it;
        bit add;
        m_pat = 8'b1100_1101;
        ld_cnt = 0; sh_cnt = 0; sub_cnt = 0; overlap = 0; done_first = 0;
        Run = 1'b1; M = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
                exp = 8'b1000_0010;
                M = 1'b1;
            end else if (c <= 17) begin
                it  = (c - 2) / 2;
                add = (c % 2 == 0);
                M   = add ? m_pat[it] : 1'b1;
                exp = {1'b0, add & m_pat[it], 2'b00, !add, add & m_pat[it] & (it == 7), 1'b1, 1'b0};
            end else begin
                M   = 1'b1;
                exp = 8'b0000_0001;
            end
            #1;
            n_cmp++;
            if (outs8 !== exp) begin n_err++; $display("FAIL mul8_cycle%0d: got %b want %b", c, outs8, exp); end
            if (c >= 2 && c <= 17) begin
                n_cmp++;
                if (Iter !== 3'((c - 2) / 2)) begin n_err++; $display("FAIL mul8_iter_cycle%0d: got %0d want %0d", c, Iter, (c - 2) / 2); end
            end
            if (Ld_A) ld_cnt++;
            if (Shift_En) sh_cnt++;
            if (Sub) sub_cnt++;
            if (Ld_A && Shift_En) overlap++;
            if (Done && done_first == 0) done_first = c;
        end
        n_cmp++;
        if (ld_cnt != 5) begin n_err++; $display("FAIL mul8_lda_count: got %0d want 5", ld_cnt); end
        n_cmp++;
        if (sh_cnt != 8) begin n_err++; $display("FAIL mul8_shift_count: got %0d want 8", sh_cnt); end
        n_cmp++;
        if (sub_cnt != 1) begin n_err++; $display("FAIL mul8_sub_count: got %0d want 1", sub_cnt); end
        n_cmp++;
        if (overlap != 0) begin n_err++; $display("FAIL mul8_overlap: got %0d want 0", overlap); end
        n_cmp++;
        if (done_first != 18) begin n_err++; $display("FAIL mul8_done_cycle: got %0d want 18", done_first); end
        Run = 1'b0; M = 1'b0; #1;
        n_cmp++;
        if (outs8 !== 8'b0000_0001) begin n_err++; $display("FAIL hold_run_low: got %b want %b", outs8, 8'b0000_0001); end
        tick();
        n_cmp++;
        if (outs8 !== 8'b0) begin n_err++; $display("FAIL back_to_idle: got %b want %b", outs8, 8'b0); end
        n_cmp++;
        if (Iter !== 3'd7) begin n_err++; $display("FAIL idle_iter_hold: got %0d want 7", Iter); end
        do_reset();
    endtask

    task automatic test_n4;
        int ld_cnt, sh_cnt, sub_cnt, sub_bad, done_first, busy_hold;
        ld_cnt = 0; sh_cnt = 0; sub_cnt = 0; sub_bad = 0; done_first = 0; busy_hold = 0;
        Run4 = 1'b1; M4 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            #1;
            if (Ld_A4) ld_cnt++;
            if (Shift_En4) sh_cnt++;
            if (Sub4) begin
                sub_cnt++;
                if (Iter4 !== 2'd3) sub_bad++;
            end
            if (Done4 && done_first == 0) done_first = c;
            if (Done4 && Busy4) busy_hold++;
        end
        n_cmp++;
        if (ld_cnt != 4) begin n_err++; $display("FAIL n4_lda_count: got %0d want 4", ld_cnt); end
        n_cmp++;
        if (sh_cnt != 4) begin n_err++; $display("FAIL n4_shift_count: got %0d want 4", sh_cnt); end
        n_cmp++;
        if (sub_cnt != 1 || sub_bad != 0) begin n_err++; $display("FAIL n4_sub: got count %0d bad %0d want 1/0", sub_cnt, sub_bad); end
        n_cmp++;
        if (done_first != 10) begin n_err++; $display("FAIL n4_done_cycle: got %0d want 10", done_first); end
        n_cmp++;
        if (busy_hold != 0) begin n_err++; $display("FAIL n4_busy_in_hold: got %0d want 0", busy_hold); end
        Run4 = 1'b0;
        tick();
        n_cmp++;
        if (outs4 !== 8'b0) begin n_err++; $display("FAIL n4_idle: got %b want %b", outs4, 8'b0); end
        do_reset();
    endtask

    task automatic test_reset_mid;
        int pulses, ld_cnt, sh_cnt, done_first, first_iter;
        pulses = 0; ld_cnt = 0; sh_cnt = 0; done_first = 0; first_iter = -1;
        Run = 1'b1; M = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        #1;
        n_cmp++;
        if (Iter !== 3'd4 || Ld_A !== 1'b1) begin n_err++; $display("FAIL mid_at_add4: got iter %0d lda %b want 4/1", Iter, Ld_A); end
        #2;
        Reset = 1'b1; cl = 1'b1; ls = 1'b1; #1;
        n_cmp++;
        if (outs8 !== 8'b0) begin n_err++; $display("FAIL mid_async_outs: got %b want %b", outs8, 8'b0); end
        n_cmp++;
        if (Iter !== 3'd0) begin n_err++; $display("FAIL mid_async_iter: got %0d want 0", Iter); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (Ld_A || Shift_En || outs8 != 8'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL mid_no_pulses: got %0d want 0", pulses); end
        Reset = 1'b0; cl = 1'b0; ls = 1'b0; #1;
        n_cmp++;
        if (outs8 !== 8'b0) begin n_err++; $display("FAIL mid_release_idle: got %b want %b", outs8, 8'b0); end
        tick();
        n_cmp++;
        if (outs8 !== 8'b1000_0010) begin n_err++; $display("FAIL mid_clear_first_edge: got %b want %b", outs8, 8'b1000_0010); end
        for (int c = 2; c <= 25; c++) begin
            tick();
            #1;
            if (c == 2) first_iter = int'(Iter);
            if (Ld_A) ld_cnt++;
            if (Shift_En) sh_cnt++;
            if (Done && done_first == 0) done_first = c;
        end
        n_cmp++;
        if (first_iter != 0) begin n_err++; $display("FAIL mid_restart_iter: got %0d want 0", first_iter); end
        n_cmp++;
        if (ld_cnt != 8 || sh_cnt != 8) begin n_err++; $display("FAIL mid_full_run: got lda %0d shift %0d want 8/8", ld_cnt, sh_cnt); end
        n_cmp++;
        if (done_first != 18) begin n_err++; $display("FAIL mid_done_cycle: got %0d want 18", done_first); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_idle_loads();
        test_multiply8();
        test_n4();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
